regfile_dump_ctrl: RTL and testbench
====================================

// Module: regfile_dump_ctrl
// PURPOSE
//  Debug-side controller that shares the register-file rs read port between the ID stage and a dump engine.
//  On request: halts the front end, lets in-flight instructions retire, then reads r0..r(NUM_REGS-1).
//  Each register is streamed as 4 bytes, LSB first, on a valid/ready byte interface (feeds the UART TX framer).
//  Sits between ID (rs address source) and REGMEM (read port 1, data_1); drives the pipeline halt.
// PARAMETERS
//  NUM_REGS      32  registers dumped, starting at r0
//  DRAIN_CYCLES  4   halted cycles before the first read (EX/MEM/WB retire)
//  ADDR_W        5   register address width; NUM_REGS <= 2**ADDR_W
// PORTS
//  i_clk        in   1       clock; everything is sampled on the rising edge
//  i_reset      in   1       synchronous, active-high reset
//  i_dump_req   in   1       start a dump; level-sampled in IDLE only
//  i_id_rs      in   ADDR_W  ID-stage rs, forwarded to REGMEM when not dumping
//  i_reg_data   in   32      REGMEM data_1 (combinational read of o_rs_sel)
//  i_ready      in   1       downstream accepts o_data this cycle
//  o_rs_sel     out  ADDR_W  REGMEM rs read address (muxed)
//  o_pipe_halt  out  1       freeze PC and IF/ID; ID inserts bubbles into ID/EX
//  o_data       out  8       current dump byte
//  o_valid      out  1       o_data is valid
//  o_busy       out  1       dump in progress (any state but IDLE)
//  o_done       out  1       one-cycle pulse after the last byte is accepted
// BEHAVIOUR
//  Reset: state=IDLE; reg_idx=0; byte_idx=0; cnt=0; word_q=0.
//   Outputs after reset: o_pipe_halt=0, o_valid=0, o_busy=0, o_done=0, o_data=0.
//   o_rs_sel=i_id_rs after reset.
//  Mux: o_rs_sel = (state==LOAD) ? reg_idx : i_id_rs. This is combinational; REGMEM needs no other change.
//  FSM (registered state; outputs decoded from state):
//   IDLE:  halt=0, busy=0. On i_dump_req=1: go to DRAIN with cnt=0. Halt rises in the next cycle.
//   DRAIN: halt=1, busy=1. cnt increments each cycle. At cnt==DRAIN_CYCLES-1: go to LOAD with reg_idx=0.
//   LOAD:  one cycle. Drives reg_idx on o_rs_sel and captures i_reg_data into word_q.
//          Sets byte_idx=0, then goes to SEND.
//   SEND:  o_valid=1, o_data=word_q[8*byte_idx +: 8].
//          A beat transfers only when o_valid && i_ready.
//          On transfer: if byte_idx<3, byte_idx++.
//          If byte_idx==3 and reg_idx<NUM_REGS-1: reg_idx++, then go to LOAD.
//          If byte_idx==3 and reg_idx==NUM_REGS-1: go to DONE.
//   DONE:  o_done=1, halt=1, busy=1 for exactly one cycle, then IDLE. Halt drops in the cycle after DONE.
//  Handshake:
//   - o_data stays stable while o_valid=1 and i_ready=0. o_valid never drops before its transfer.
//   - i_ready may be held high continuously. Steady-state throughput is 4 bytes per 5 cycles.
//   - i_ready is ignored outside SEND.
//  Latency: first byte is valid 1+DRAIN_CYCLES+1 cycles after i_dump_req is sampled (6 with the default).
//  Boundaries:
//   - i_dump_req while busy is ignored; no queuing. After DONE->IDLE, a still-high req starts a new dump.
//   - r0 is read through REGMEM and reads as 0.
//   - No REGMEM write hazard: the drain guarantees WB is idle, so no bypass is needed.
//   - Reset mid-dump (any state): IDLE next cycle, halt released, o_valid low, the partial dump is dropped.
//   - reg_idx counts to NUM_REGS-1 only and never wraps.
//   - cnt is wide enough for DRAIN_CYCLES. DRAIN_CYCLES=1 gives a one-cycle DRAIN.
// STRUCTURE
//  Shared package mips_dbg_pkg:
//   - state encoding localparams (IDLE, DRAIN, LOAD, SEND, DONE)
//   - BYTES_PER_WORD=4 and the default DRAIN_CYCLES
//  Sub-module dump_byte_serializer: word_q, byte_idx and the valid/ready slice. Returns word_done.
//  The FSM, counters and rs mux stay in the top module.
// TESTING
//  1 Reset: hold i_reset 2 cycles -> all outputs 0, o_rs_sel==i_id_rs (drive 5'd9, see 9).
//  2 Full dump, ready=1: preload rK=32'hA5000000|K, pulse req ->
//    o_pipe_halt=1 from cycle +1; first byte 8'h00 (r0) at cycle +6;
//    128 bytes; bytes 4..7 = 01,00,00,A5; o_done one cycle; halt=0 next cycle.
//  3 Backpressure: i_ready toggles 1010.. with r1=32'h12345678 ->
//    o_data holds 78 until accepted, then 56,34,12; no byte lost or duplicated.
//  4 Req while busy: second req pulse during SEND of r3 -> still exactly 128 bytes and one o_done.
//  5 Reset mid-dump: assert i_reset during SEND of r10 ->
//    next cycle o_valid=0, halt=0, busy=0; a new req restarts at r0.
//  6 Mux pass-through: IDLE, sweep i_id_rs 0..31 -> o_rs_sel follows in the same cycle.
//    During LOAD, o_rs_sel==reg_idx regardless of i_id_rs.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared debug-controller types and constants
// for the register-file dump path.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } dump_state_e;

    localparam int BYTES_PER_WORD   = 4;
    localparam int DEF_DRAIN_CYCLES = 4;

endpackage

// File: rtl/dump_byte_serializer.sv
// Holds one captured register word and streams it
// LSB first over a valid/ready byte slice.
module dump_byte_serializer
    import mips_dbg_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic        i_send,
    input  logic [31:0] i_word,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_word_done
);

    localparam int BIDX_W = $clog2(BYTES_PER_WORD);

    logic [31:0]       word_q, word_d;
    logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
    logic              xfer;
    logic              last;

    assign o_valid     = i_send;
    assign xfer        = i_send && i_ready;
    assign last        = byte_idx_q == BIDX_W'(BYTES_PER_WORD - 1);
    assign o_word_done = xfer && last;
    assign o_data      = word_q[{byte_idx_q, 3'b000} +: 8];

    always_comb begin
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        if (i_load) begin
            word_d     = i_word;
            byte_idx_d = '0;
        end else if (xfer && !last) begin
            byte_idx_d = byte_idx_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            word_q     <= '0;
            byte_idx_q <= '0;
        end else begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Shares the REGMEM rs read port between ID and a
// dump engine that halts, drains, then streams r0..rN.
module regfile_dump_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int ADDR_W       = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_dump_req,
    input  logic [ADDR_W-1:0] i_id_rs,
    input  logic [31:0]       i_reg_data,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_rs_sel,
    output logic              o_pipe_halt,
    output logic [7:0]        o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    dump_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] reg_idx_q, reg_idx_d;
    logic              load;
    logic              send;
    logic              word_done;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reg_idx_d   = reg_idx_q;
        o_pipe_halt = 1'b1;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        load        = 1'b0;
        send        = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_pipe_halt = 1'b0;
                o_busy      = 1'b0;
                if (i_dump_req) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d   = LOAD;
                    reg_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                send = 1'b1;
                if (word_done) begin
                    if (reg_idx_q == ADDR_W'(NUM_REGS - 1)) begin
                        state_d = DONE;
                    end else begin
                        reg_idx_d = reg_idx_q + 1'b1;
                        state_d   = LOAD;
                    end
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            reg_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reg_idx_q <= reg_idx_d;
        end
    end

    // Only LOAD steals the read port; ID sees it otherwise.
    assign o_rs_sel = load ? reg_idx_q : i_id_rs;

    dump_byte_serializer u_ser (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (load),
        .i_send      (send),
        .i_word      (i_reg_data),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_word_done (word_done)
    );

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl with a
// behavioural REGMEM and a byte-stream reference model.
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset, req, ready;
    logic [4:0]  id_rs, rs_sel;
    logic [31:0] reg_data;
    logic        halt, valid, busy, done;
    logic [7:0]  data;

    logic [31:0] regs [32];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign reg_data = regs[rs_sel];

    regfile_dump_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_dump_req  (req),
        .i_id_rs     (id_rs),
        .i_reg_data  (reg_data),
        .i_ready     (ready),
        .o_rs_sel    (rs_sel),
        .o_pipe_halt (halt),
        .o_data      (data),
        .o_valid     (valid),
        .o_busy      (busy),
        .o_done      (done)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] exp_sel;
        logic       exp_busy;
        logic       exp_halt;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [32];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int k = 0; k < 32; k++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(regs[k][8*b +: 8]);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        build_expected();
        chk({tag, "_count"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic rand_regs();
        regs[0] = 32'h0;
        for (int k = 1; k < 32; k++) regs[k] = $urandom;
    endtask

    // mode 0: ready=1, 1: toggling, 2: random
    task automatic run_dump(input int mode, input bit req_again,
                            input int rst_at, output int first_cyc,
                            output int done_cyc, output int ndone);
        logic       pv, pr;
        logic [7:0] pd;
        logic [4:0] exp_sel;
        got.delete();
        ndone = 0; first_cyc = -1; done_cyc = -1;
        pv = 1'b0; pr = 1'b0; pd = 8'h0;
        req = 1'b1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            step();
            req   = req_again && (got.size() == 13);
            ready = (mode == 0) ? 1'b1 :
                    (mode == 1) ? (cyc % 2 == 1) :
                    1'($urandom_range(0, 1));
            id_rs = 5'($urandom_range(0, 31));
            if (rst_at > 0 && got.size() == rst_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                #1;
                chk("rst_valid", valid, 0);
                chk("rst_halt", halt, 0);
                chk("rst_busy", busy, 0);
                return;
            end
            #1;
            if (cyc == 1) begin
                chk("halt_c1", halt, 1);
                chk("busy_c1", busy, 1);
            end
            if (valid && first_cyc < 0) first_cyc = cyc;
            if (pv && !pr) begin
                chk("hold_valid", valid, 1);
                chk("hold_data", data, pd);
            end
            if (mode == 0) begin
                exp_sel = (cyc >= 5 && cyc <= 160 && (cyc - 5) % 5 == 0)
                          ? 5'((cyc - 5) / 5) : id_rs;
                chk($sformatf("rs_sel_c%0d", cyc), rs_sel, exp_sel);
            end
            if (valid && ready) got.push_back(data);
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                chk("halt_after_done", halt, 0);
                chk("busy_after_done", busy, 0);
                return;
            end
            pv = valid; pr = ready; pd = data;
        end
        n_chk++;
        $display("FAIL timeout: dump did not finish in 2000 cycles");
    endtask

    initial begin
        int fc, dc, nd;
        reset = 1'b1; req = 1'b0; ready = 1'b0; id_rs = 5'd9;
        for (int k = 0; k < 32; k++) regs[k] = 32'h0;
        step();
        step();
        chk("reset_halt", halt, 0);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_data", data, 0);
        chk("reset_rs_sel", rs_sel, 9);
        reset = 1'b0;
        step();

        for (int i = 0; i < 32; i++)
            vecs[i] = '{rs: 5'(31 - i), exp_sel: 5'(31 - i),
                        exp_busy: 1'b0, exp_halt: 1'b0, exp_valid: 1'b0};
        for (int i = 0; i < 32; i++) begin
            id_rs = vecs[i].rs;
            #1;
            chk($sformatf("mux_sel%0d", i), rs_sel, vecs[i].exp_sel);
            chk("mux_busy", busy, vecs[i].exp_busy);
            chk("mux_halt", halt, vecs[i].exp_halt);
            chk("mux_valid", valid, vecs[i].exp_valid);
            step();
        end

        regs[0] = 32'h0;
        for (int k = 1; k < 32; k++) regs[k] = 32'hA500_0000 | k;
        run_dump(0, 1'b0, 0, fc, dc, nd);
        chk("full_first_cyc", fc, 6);
        chk("full_ndone", nd, 1);
        chk("full_done_cyc", dc, 165);
        chk("full_b0", got.size() > 0 ? got[0] : 8'hxx, 8'h00);
        chk("full_b4", got.size() > 7 ? got[4] : 8'hxx, 8'h01);
        chk("full_b5", got.size() > 7 ? got[5] : 8'hxx, 8'h00);
        chk("full_b6", got.size() > 7 ? got[6] : 8'hxx, 8'h00);
        chk("full_b7", got.size() > 7 ? got[7] : 8'hxx, 8'hA5);
        compare_stream("full");

        regs[1] = 32'h1234_5678;
        run_dump(1, 1'b0, 0, fc, dc, nd);
        chk("bp_first_cyc", fc, 6);
        chk("bp_ndone", nd, 1);
        chk("bp_b4", got.size() > 7 ? got[4] : 8'hxx, 8'h78);
        chk("bp_b5", got.size() > 7 ? got[5] : 8'hxx, 8'h56);
        chk("bp_b6", got.size() > 7 ? got[6] : 8'hxx, 8'h34);
        chk("bp_b7", got.size() > 7 ? got[7] : 8'hxx, 8'h12);
        compare_stream("bp");

        rand_regs();
        run_dump(0, 1'b1, 0, fc, dc, nd);
        chk("rebusy_ndone", nd, 1);
        compare_stream("rebusy");
        step();
        chk("rebusy_idle", busy, 0);

        rand_regs();
        run_dump(2, 1'b0, 41, fc, dc, nd);
        step();
        chk("post_rst_busy", busy, 0);
        run_dump(2, 1'b0, 0, fc, dc, nd);
        chk("restart_first_cyc", fc, 6);
        chk("restart_ndone", nd, 1);
        compare_stream("restart");

        for (int r = 0; r < 3; r++) begin
            rand_regs();
            run_dump(2, 1'b0, 0, fc, dc, nd);
            chk($sformatf("rand%0d_ndone", r), nd, 1);
            compare_stream($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
